// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared gray-code helpers and monitor state type
package gray_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} gray_mon_state_t;

  // Operands are zero-extended to GRAY_MAX_W; callers truncate the result.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// rtl/gray_to_bin.sv - combinational XOR-prefix gray to binary decoder
module gray_to_bin #(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] gray,
  output logic [DATA_WIDTH-1:0] bin
);

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[DATA_WIDTH-1:i];
  end

endmodule

// File: rtl/gray_seq_monitor.sv
// rtl/gray_seq_monitor.sv - gray counter sequence checker with lock tracking
module gray_seq_monitor
  import gray_pkg::*;
#(
  parameter int DATA_WIDTH    = 4,
  parameter int ERR_CNT_WIDTH = 8,
  parameter int LOCK_LOSS     = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_gray,
  input  logic                     err_clr,
  output logic [DATA_WIDTH-1:0]    bin_out,
  output logic                     bin_valid,
  output logic                     wrap_pulse,
  output logic                     err_pulse,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic                     locked
);

  localparam int CW = $clog2(LOCK_LOSS + 1);

  gray_mon_state_t          state, state_n;
  logic [DATA_WIDTH-1:0]    prev_gray;
  logic [CW-1:0]            consec_err, consec_n, consec_inc;
  logic [ERR_CNT_WIDTH-1:0] err_n;
  logic [DATA_WIDTH-1:0]    in_bin, prev_bin, next_bin, exp_gray;
  logic                     chk, is_hold, is_step, is_err, is_wrap;

  gray_to_bin #(.DATA_WIDTH(DATA_WIDTH)) u_dec_in (
    .gray (in_gray),
    .bin  (in_bin)
  );

  gray_to_bin #(.DATA_WIDTH(DATA_WIDTH)) u_dec_prev (
    .gray (prev_gray),
    .bin  (prev_bin)
  );

  assign next_bin   = prev_bin + DATA_WIDTH'(1);
  assign exp_gray   = DATA_WIDTH'(bin2gray(GRAY_MAX_W'(next_bin)));
  assign chk        = in_valid && (state == LOCKED);
  assign is_hold    = (in_gray == prev_gray);
  assign is_step    = (in_gray == exp_gray);
  assign is_err     = chk && !is_hold && !is_step;
  assign is_wrap    = chk && is_step && (prev_bin == '1);
  assign consec_inc = consec_err + CW'(1);
  assign locked     = (state == LOCKED);

  always_comb begin
    state_n  = state;
    consec_n = consec_err;
    err_n    = err_count;
    if (in_valid) begin
      if (state == UNLOCKED) begin
        state_n  = LOCKED;
        consec_n = '0;
      end else if (is_err) begin
        if (consec_inc == CW'(LOCK_LOSS)) begin
          state_n  = UNLOCKED;
          consec_n = '0;
        end else begin
          consec_n = consec_inc;
        end
      end else begin
        consec_n = '0;
      end
    end
    // A clear coinciding with an error keeps that error counted.
    if (err_clr) begin
      err_n = is_err ? ERR_CNT_WIDTH'(1) : '0;
    end else if (is_err && (err_count != '1)) begin
      err_n = err_count + ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= UNLOCKED;
      prev_gray  <= '0;
      consec_err <= '0;
      err_count  <= '0;
      bin_out    <= '0;
      bin_valid  <= 1'b0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      state      <= state_n;
      consec_err <= consec_n;
      err_count  <= err_n;
      bin_valid  <= in_valid;
      wrap_pulse <= is_wrap;
      err_pulse  <= is_err;
      if (in_valid) begin
        bin_out   <= in_bin;
        prev_gray <= in_gray;
      end
    end
  end

endmodule
